// File: rtl/graph_mem_arbiter.sv
// graph_mem_arbiter: round-robin sharing of one graph_memory read port among
// NUM_REQ requesters. One grant per cycle, requests are registered toward the
// memory, and a tag FIFO of requester IDs steers in-order read data back to
// the requester that issued it.
module graph_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_REQ-1:0]                 req_valid_in,
    input  logic [ADDR_WIDTH-1:0]              req_addr_in [NUM_REQ],
    output logic [NUM_REQ-1:0]                 req_ready_out,
    output logic [DATA_WIDTH-1:0]              rsp_data_out,
    output logic [NUM_REQ-1:0]                 rsp_valid_out,
    output logic [ADDR_WIDTH-1:0]              mem_req_out,
    output logic                               mem_valid_out,
    input  logic [DATA_WIDTH-1:0]              mem_data_in,
    input  logic                               mem_valid_in,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_out,
    output logic                               err_out
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FA_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    // Round-robin pointer and issue-side registers
    logic [ID_W-1:0]       r_ptr;
    logic [ADDR_WIDTH-1:0] r_mem_req;
    logic                  r_mem_valid;

    // Response-side registers
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic                  r_err;

    // Tag FIFO: requester IDs of requests in flight, oldest at r_rd_ptr
    logic [ID_W-1:0]       r_tag_mem [MAX_OUTSTANDING];
    logic [FA_W-1:0]       r_wr_ptr;
    logic [FA_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_eligible;
    logic                  w_found;
    logic [ID_W-1:0]       w_winner;
    logic [ID_W-1:0]       w_ptr_next;
    logic                  w_push;
    logic                  w_pop;
    logic [ID_W-1:0]       w_head;

    // A slot must already be free at the start of the cycle; a pop in the
    // same cycle does not count, which keeps the ready path short.
    assign w_eligible = (r_count < CNT_W'(MAX_OUTSTANDING));

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        logic [ID_W:0] cand;
        w_found  = 1'b0;
        w_winner = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && w_eligible && req_valid_in[cand[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = cand[ID_W-1:0];
            end
        end
    end

    // One-hot ready on the winning requester
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_out[gi] = w_found && (w_winner == ID_W'(gi));
        end
    endgenerate

    // Ready is only raised on a valid requester, so a winner is a handshake
    assign w_push     = w_found;
    assign w_pop      = mem_valid_in && (r_count != '0);
    assign w_head     = r_tag_mem[r_rd_ptr];
    assign w_ptr_next = (w_winner == ID_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

    // Issue path: register the winning address toward memory and advance pointer
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ptr       <= '0;
            r_mem_req   <= '0;
            r_mem_valid <= 1'b0;
        end else if (w_push) begin
            r_ptr       <= w_ptr_next;
            r_mem_req   <= req_addr_in[w_winner];
            r_mem_valid <= 1'b1;
        end else begin
            r_mem_valid <= 1'b0;
        end
    end

    // Tag storage needs no reset: entries are only read below the count
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

    // Tag FIFO pointers and occupancy count
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == FA_W'(MAX_OUTSTANDING-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == FA_W'(MAX_OUTSTANDING-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response path: steer returning data to the oldest tag, flag orphan data
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
            r_err       <= 1'b0;
        end else if (w_pop) begin
            r_rsp_data  <= mem_data_in;
            r_rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_head;
        end else begin
            r_rsp_valid <= '0;
            if (mem_valid_in) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req_out     = r_mem_req;
    assign mem_valid_out   = r_mem_valid;
    assign rsp_data_out    = r_rsp_data;
    assign rsp_valid_out   = r_rsp_valid;
    assign outstanding_out = r_count;
    assign err_out         = r_err;

endmodule
